// File: rtl/motor_pkg.sv
// Shared types and constants for the motor job scheduler: mode encodings, coil patterns,
// FSM states and the per-mode duration table.
package motor_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StGap} state_e;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  localparam logic [3:0] PH_A = 4'b1001;
  localparam logic [3:0] PH_B = 4'b1010;
  localparam logic [3:0] PH_C = 4'b0110;
  localparam logic [3:0] PH_D = 4'b0101;

  // Job length in duration units; 0 for mode 2 and out-of-range pads (never accepted).
  function automatic logic [5:0] dur_units(input logic [1:0] mode, input logic [3:0] idx);
    logic [5:0] units;
    units = 6'd0;
    case (mode)
      MODE_0: begin
        case (idx)
          4'd0, 4'd2, 4'd6, 4'd8: units = 6'd16;
          4'd1, 4'd3, 4'd5, 4'd7: units = 6'd8;
          4'd4:                   units = 6'd32;
          default:                units = 6'd0;
        endcase
      end
      MODE_1: begin
        case (idx)
          4'd0, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: units = 6'd6;
          4'd1, 4'd3, 4'd4:                   units = 6'd3;
          default:                            units = 6'd0;
        endcase
      end
      MODE_3: units = (idx <= 4'd8) ? 6'd8 : 6'd0;
      default: units = 6'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/motor_phase_gen.sv
// Four-phase coil sequencer: steps through PH_A..PH_D once per STEP_PERIOD clocks while en is high,
// and parks on PH_A when disabled.
module motor_phase_gen
  import motor_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 2000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       en,
  output logic [3:0] MOTOR_OUT
);

  localparam logic [31:0] CntLast = 32'(STEP_PERIOD - 1);
  localparam logic [31:0] CntQ1   = 32'(STEP_PERIOD / 4);
  localparam logic [31:0] CntQ2   = 32'(STEP_PERIOD / 2);
  localparam logic [31:0] CntQ3   = 32'((STEP_PERIOD / 4) * 3);

  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  pat_q, pat_d;

  always_comb begin
    cnt_d = cnt_q;
    pat_d = pat_q;
    if (!en) begin
      cnt_d = 32'd0;
      pat_d = PH_A;
    end else begin
      cnt_d = (cnt_q == CntLast) ? 32'd0 : cnt_q + 32'd1;
      // Pattern register trails the quarter-point by one cycle.
      if (cnt_q == 32'd0) begin
        pat_d = PH_A;
      end else if (cnt_q == CntQ1) begin
        pat_d = PH_B;
      end else if (cnt_q == CntQ2) begin
        pat_d = PH_C;
      end else if (cnt_q == CntQ3) begin
        pat_d = PH_D;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= 32'd0;
      pat_q <= PH_A;
    end else begin
      cnt_q <= cnt_d;
      pat_q <= pat_d;
    end
  end

  // Parked pattern shows immediately when the motor is switched off.
  assign MOTOR_OUT = en ? pat_q : PH_A;

endmodule

// File: rtl/motor_job_scheduler.sv
// Queues pad presses as timed motor jobs and runs them one at a time through motor_phase_gen.
// Mode changes flush the queue and abort the running job.
module motor_job_scheduler
  import motor_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 6000000,
  parameter int unsigned STEP_PERIOD = 2000000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned GAP_UNITS   = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] LEFT_KEY,
  input  logic       MODE_SWITCH,
  input  logic [8:0] KEY,
  output logic [3:0] MOTOR_OUT,
  output logic       MOTOR_ON,
  output logic       BUSY,
  output logic [$clog2(FIFO_DEPTH):0] QUEUE_CNT,
  output logic       OVERFLOW,
  output logic [1:0] MODE,
  output logic       MODE_VALID
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] PtrOne   = (PtrW + 1)'(1);
  localparam logic [31:0]   TickLast = 32'(TICK_DIV - 1);
  localparam logic [5:0]    GapUnits = 6'(GAP_UNITS);

  state_e        state_q, state_d;
  logic [31:0]   tick_q, tick_d;
  logic [5:0]    unit_q, unit_d;
  logic [8:0]    key_q;
  logic [1:0]    mode_q, mode_d;
  logic          mode_valid_q, mode_valid_d;
  logic          ovf_q, ovf_d;
  logic [PtrW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    fifo_mem [FIFO_DEPTH];

  logic          lk_hit, mode_change, mode_en;
  logic [1:0]    lk_mode;
  logic [8:0]    rise;
  logic          req_vld;
  logic [3:0]    req_idx, head_idx;
  logic [PtrW:0] count;
  logic          empty, full, push, pop;

  // Mode select: lowest set LEFT_KEY bit wins.
  always_comb begin
    lk_hit  = |LEFT_KEY;
    lk_mode = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (LEFT_KEY[i]) lk_mode = 2'(i);
    end
    mode_change  = lk_hit && (!mode_valid_q || (lk_mode != mode_q));
    mode_d       = lk_hit ? lk_mode : mode_q;
    mode_valid_d = mode_valid_q | lk_hit;
  end

  // Request: lowest-index rising pad edge.
  always_comb begin
    rise    = KEY & ~key_q;
    req_vld = |rise;
    req_idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (rise[i]) req_idx = 4'(i);
    end
  end

  assign mode_en = mode_valid_q &&
                   ((mode_q == MODE_0) || (mode_q == MODE_1) ||
                    ((mode_q == MODE_3) && MODE_SWITCH));

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (count == DepthCnt);
  assign head_idx = fifo_mem[rd_ptr_q[PtrW-1:0]];
  assign pop      = (state_q == StLoad) && !empty;

  // A pop in the same cycle frees the slot a full queue would otherwise reject.
  always_comb begin
    push     = req_vld && mode_en && (!full || pop) && !mode_change;
    ovf_d    = req_vld && mode_en && full && !pop && !mode_change;
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    if (mode_change) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= req_idx;
  end

  // FSM next state and duration counters.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StLoad;
      end
      StLoad: begin
        state_d = StRun;
        unit_d  = dur_units(mode_q, head_idx);
        tick_d  = 32'd0;
      end
      StRun: begin
        if (tick_q == TickLast) begin
          tick_d = 32'd0;
          unit_d = unit_q - 6'd1;
          if (unit_q == 6'd1) begin
            if (GapUnits == 6'd0) begin
              state_d = StIdle;
            end else begin
              state_d = StGap;
              unit_d  = GapUnits;
            end
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      StGap: begin
        if (tick_q == TickLast) begin
          tick_d = 32'd0;
          unit_d = unit_q - 6'd1;
          if (unit_q == 6'd1) state_d = StIdle;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (mode_change) begin
      state_d = StIdle;
      tick_d  = 32'd0;
      unit_d  = 6'd0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      tick_q       <= 32'd0;
      unit_q       <= 6'd0;
      key_q        <= 9'd0;
      mode_q       <= 2'd0;
      mode_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      unit_q       <= unit_d;
      key_q        <= KEY;
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_comb begin
    MOTOR_ON   = (state_q == StRun);
    BUSY       = (state_q != StIdle) || !empty;
    QUEUE_CNT  = count;
    OVERFLOW   = ovf_q;
    MODE       = mode_q;
    MODE_VALID = mode_valid_q;
  end

  motor_phase_gen #(
    .STEP_PERIOD(STEP_PERIOD)
  ) u_phase_gen (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .en       (MOTOR_ON),
    .MOTOR_OUT(MOTOR_OUT)
  );

endmodule

// File: tb/tb_motor_job_scheduler.sv
// Directed bench for motor_job_scheduler: table vectors for short sequences plus hand-written
// multi-cycle checks for run length, coil stepping, overflow, abort and async reset.
module tb_motor_job_scheduler;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] LEFT_KEY;
  logic       MODE_SWITCH;
  logic [8:0] KEY;
  logic [3:0] MOTOR_OUT;
  logic       MOTOR_ON;
  logic       BUSY;
  logic [2:0] QUEUE_CNT;
  logic       OVERFLOW;
  logic [1:0] MODE;
  logic       MODE_VALID;

  int n_chk;
  int n_err;

  typedef struct {
    logic [3:0] lk;
    logic       sw;
    logic [8:0] key;
    logic       mv;
    logic [1:0] mode;
    logic [2:0] q;
    logic       busy;
    logic       on;
    logic [3:0] out;
    logic       ovf;
  } vec_t;

  vec_t vecs [11];

  motor_job_scheduler #(
    .TICK_DIV   (4),
    .STEP_PERIOD(8),
    .FIFO_DEPTH (4),
    .GAP_UNITS  (1)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .LEFT_KEY   (LEFT_KEY),
    .MODE_SWITCH(MODE_SWITCH),
    .KEY        (KEY),
    .MOTOR_OUT  (MOTOR_OUT),
    .MOTOR_ON   (MOTOR_ON),
    .BUSY       (BUSY),
    .QUEUE_CNT  (QUEUE_CNT),
    .OVERFLOW   (OVERFLOW),
    .MODE       (MODE),
    .MODE_VALID (MODE_VALID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_out", idx, 32'(MOTOR_OUT), 32'h9);
    chk("rst_on", idx, 32'(MOTOR_ON), 32'd0);
    chk("rst_busy", idx, 32'(BUSY), 32'd0);
    chk("rst_qcnt", idx, 32'(QUEUE_CNT), 32'd0);
    chk("rst_ovf", idx, 32'(OVERFLOW), 32'd0);
    chk("rst_mode", idx, 32'(MODE), 32'd0);
    chk("rst_mvalid", idx, 32'(MODE_VALID), 32'd0);
  endtask

  task automatic apply_vec(input int i);
    LEFT_KEY    = vecs[i].lk;
    MODE_SWITCH = vecs[i].sw;
    KEY         = vecs[i].key;
    tick();
    chk("vec_mvalid", i, 32'(MODE_VALID), 32'(vecs[i].mv));
    chk("vec_mode", i, 32'(MODE), 32'(vecs[i].mode));
    chk("vec_qcnt", i, 32'(QUEUE_CNT), 32'(vecs[i].q));
    chk("vec_busy", i, 32'(BUSY), 32'(vecs[i].busy));
    chk("vec_on", i, 32'(MOTOR_ON), 32'(vecs[i].on));
    chk("vec_out", i, 32'(MOTOR_OUT), 32'(vecs[i].out));
    chk("vec_ovf", i, 32'(OVERFLOW), 32'(vecs[i].ovf));
  endtask

  // Coil pattern k cycles into RUN with STEP_PERIOD=8: PH_A held until the first quarter
  // point is registered, then a new pattern every 2 cycles.
  function automatic logic [3:0] exp_pat(input int k);
    int q;
    if (k == 0) return 4'b1001;
    q = ((k - 1) % 8) / 2;
    case (q)
      0:       return 4'b1001;
      1:       return 4'b1010;
      2:       return 4'b0110;
      default: return 4'b0101;
    endcase
  endfunction

  initial begin
    int n;
    int ovf_cnt;
    n_chk       = 0;
    n_err       = 0;
    RESET_N     = 1'b0;
    LEFT_KEY    = 4'd0;
    MODE_SWITCH = 1'b0;
    KEY         = 9'd0;

    //              lk       sw    key            mv    mode   q     busy  on    out      ovf
    vecs[0]  = '{4'b0001, 1'b0, 9'b000000000, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 9'b000000010, 1'b1, 2'd0, 3'd1, 1'b1, 1'b0, 4'b1001, 1'b0};
    vecs[2]  = '{4'b0000, 1'b0, 9'b000000000, 1'b1, 2'd0, 3'd1, 1'b1, 1'b0, 4'b1001, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 9'b000000000, 1'b1, 2'd0, 3'd0, 1'b1, 1'b1, 4'b1001, 1'b0};
    vecs[4]  = '{4'b0100, 1'b1, 9'b000000000, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 9'b000010000, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[6]  = '{4'b0000, 1'b1, 9'b000000000, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[7]  = '{4'b1000, 1'b0, 9'b000000000, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 9'b000000001, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 9'b000000000, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 9'b000000000, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 4'b1001, 1'b0};

    // Reset state
    #2;
    chk_reset_vals(0);
    tick();
    tick();
    #2 RESET_N = 1'b1;
    tick();
    chk_reset_vals(1);

    // Basic job: mode 0, pad 1 -> 8 units = 32 RUN cycles
    for (int i = 0; i < 4; i++) apply_vec(i);
    for (int k = 0; k < 32; k++) begin
      chk("basic_on", k, 32'(MOTOR_ON), 32'd1);
      chk("basic_out", k, 32'(MOTOR_OUT), 32'(exp_pat(k)));
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      chk("gap_on", g, 32'(MOTOR_ON), 32'd0);
      chk("gap_busy", g, 32'(BUSY), 32'd1);
      chk("gap_out", g, 32'(MOTOR_OUT), 32'h9);
      tick();
    end
    chk("basic_done_busy", 0, 32'(BUSY), 32'd0);

    // Simultaneous edges: mode 1, pads 2 and 4 together -> only pad 2 (6 units)
    LEFT_KEY = 4'b0010;
    tick();
    chk("sim_mode", 0, 32'(MODE), 32'd1);
    LEFT_KEY = 4'b0000;
    KEY      = 9'b000010100;
    tick();
    chk("sim_qcnt", 0, 32'(QUEUE_CNT), 32'd1);
    tick();
    tick();
    n = 0;
    while (MOTOR_ON && n < 100) begin
      n++;
      tick();
    end
    chk("sim_run_len", 0, 32'(n), 32'd24);
    KEY = 9'd0;
    repeat (4) tick();
    chk("sim_after_busy", 0, 32'(BUSY), 32'd0);
    chk("sim_after_qcnt", 0, 32'(QUEUE_CNT), 32'd0);

    // Overflow: mode 3 enabled, one job running, then 5 presses and one press on the LOAD pop
    LEFT_KEY    = 4'b1000;
    MODE_SWITCH = 1'b1;
    tick();
    chk("ovf_mode", 0, 32'(MODE), 32'd3);
    LEFT_KEY = 4'b0000;
    KEY      = 9'd1;
    tick();
    chk("ovf_first_q", 0, 32'(QUEUE_CNT), 32'd1);
    KEY = 9'd0;
    tick();
    tick();
    chk("ovf_run_on", 0, 32'(MOTOR_ON), 32'd1);
    ovf_cnt = 0;
    for (int p = 1; p <= 5; p++) begin
      KEY = 9'd1;
      tick();
      if (OVERFLOW) ovf_cnt++;
      chk("ovf_press_q", p, 32'(QUEUE_CNT), (p < 5) ? 32'(p) : 32'd4);
      chk("ovf_press_pulse", p, 32'(OVERFLOW), (p == 5) ? 32'd1 : 32'd0);
      KEY = 9'd0;
      tick();
      if (OVERFLOW) ovf_cnt++;
    end
    n = 0;
    while (MOTOR_ON && n < 64) begin
      tick();
      n++;
      if (OVERFLOW) ovf_cnt++;
    end
    chk("ovf_job_end", 0, 32'(MOTOR_ON), 32'd0);
    repeat (4) tick();
    chk("ovf_idle_on", 0, 32'(MOTOR_ON), 32'd0);
    chk("ovf_idle_q", 0, 32'(QUEUE_CNT), 32'd4);
    chk("ovf_idle_busy", 0, 32'(BUSY), 32'd1);
    tick();
    chk("ovf_load_on", 0, 32'(MOTOR_ON), 32'd0);
    KEY = 9'd1;
    tick();
    if (OVERFLOW) ovf_cnt++;
    chk("ovf_pop_push_q", 0, 32'(QUEUE_CNT), 32'd4);
    chk("ovf_pop_push_on", 0, 32'(MOTOR_ON), 32'd1);
    chk("ovf_pop_push_pulse", 0, 32'(OVERFLOW), 32'd0);
    chk("ovf_pulse_count", 0, 32'(ovf_cnt), 32'd1);

    // Gating: mode 2 and mode 3 without MODE_SWITCH accept nothing
    for (int i = 4; i < 11; i++) apply_vec(i);

    // Abort: mode 0 job running with two queued, then switch to mode 1
    LEFT_KEY = 4'b0001;
    tick();
    chk("abort_mode0", 0, 32'(MODE), 32'd0);
    LEFT_KEY = 4'b0000;
    KEY      = 9'd1;
    tick();
    KEY = 9'd0;
    tick();
    tick();
    chk("abort_run_on", 0, 32'(MOTOR_ON), 32'd1);
    repeat (3) tick();
    KEY = 9'b000000010;
    tick();
    KEY = 9'd0;
    tick();
    KEY = 9'b000000100;
    tick();
    KEY = 9'd0;
    tick();
    chk("abort_pre_q", 0, 32'(QUEUE_CNT), 32'd2);
    chk("abort_pre_on", 0, 32'(MOTOR_ON), 32'd1);
    chk("abort_pre_out", 0, 32'(MOTOR_OUT), 32'b0101);
    LEFT_KEY = 4'b0010;
    tick();
    chk("abort_on", 0, 32'(MOTOR_ON), 32'd0);
    chk("abort_out", 0, 32'(MOTOR_OUT), 32'h9);
    chk("abort_q", 0, 32'(QUEUE_CNT), 32'd0);
    chk("abort_mode", 0, 32'(MODE), 32'd1);
    chk("abort_busy", 0, 32'(BUSY), 32'd0);

    // Async reset mid-RUN
    LEFT_KEY = 4'b0000;
    KEY      = 9'd1;
    tick();
    KEY = 9'd0;
    tick();
    tick();
    repeat (5) tick();
    chk("areset_pre_on", 0, 32'(MOTOR_ON), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk_reset_vals(2);
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    repeat (6) tick();
    chk("areset_post_on", 0, 32'(MOTOR_ON), 32'd0);
    chk("areset_post_busy", 0, 32'(BUSY), 32'd0);
    chk("areset_post_q", 0, 32'(QUEUE_CNT), 32'd0);
    chk("areset_post_mvalid", 0, 32'(MODE_VALID), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
